// File: rtl/pipe_hold_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pipe_hold_ctrl
// Purpose  : Central hold/flush controller for an in-order pipeline. Turns
//            hazard, branch, trap and multi-cycle stall indications into one
//            3-bit hold code seen by every pipeline register.
//            hold_flag: 000 run, 001 flush all, 010 hold front (PC, IF/ID),
//                       011 flush front, 100 hold all.
// Ports    : clk            rising-edge clock
//            rst            synchronous reset, active low
//            ld_use_hazard  ID needs a load result not yet available
//            branch_taken   EX resolved a taken branch/jump
//            trap_req       exception/interrupt accepted
//            mem_req/ack    MEM data-bus request / completion
//            div_start/done multi-cycle divide issue / result valid
//            hold_flag      broadcast hold/flush code (combinational)
//            flush_pend     branch flush latched during a stall, awaiting replay
//            stall_timeout  one-cycle watchdog pulse
// Options  : `define PIPE_HOLD_CTRL_WDOG_EN adds an 8-bit stall watchdog that
//            aborts a stall after TIMEOUT_CYC cycles; without it stall_timeout
//            is constant 0 and stalls are unbounded.
// Revision : 1.0 - initial release
// ============================================================================
module pipe_hold_ctrl #(
    parameter int TIMEOUT_CYC = 255
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ld_use_hazard,
    input  logic       branch_taken,
    input  logic       trap_req,
    input  logic       mem_req,
    input  logic       mem_ack,
    input  logic       div_start,
    input  logic       div_done,
    output logic [2:0] hold_flag,
    output logic       flush_pend,
    output logic       stall_timeout
);

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_WAIT_MEM = 2'd1,
        ST_WAIT_DIV = 2'd2,
        ST_REPLAY   = 2'd3
    } state_t;

    localparam logic [2:0] C_HF_RUN        = 3'b000;
    localparam logic [2:0] C_HF_FLUSH_ALL  = 3'b001;
    localparam logic [2:0] C_HF_HOLD_FRONT = 3'b010;
    localparam logic [2:0] C_HF_FLUSH_FRT  = 3'b011;
    localparam logic [2:0] C_HF_HOLD_ALL   = 3'b100;

    // The watchdog counter is 8 bits wide, so the limit must fit in it.
    if (TIMEOUT_CYC < 1 || TIMEOUT_CYC > 255) begin : g_bad_timeout
        $error("pipe_hold_ctrl: TIMEOUT_CYC must be in 1..255");
    end

    state_t     state_q, state_d;
    logic       flush_q, flush_d;
    logic [2:0] w_hold;
    logic       w_in_wait;
    logic       w_wdog_fire;
    logic       w_stall_done;
    logic       w_pend_any;

    assign w_in_wait = (state_q == ST_WAIT_MEM) || (state_q == ST_WAIT_DIV);

`ifdef PIPE_HOLD_CTRL_WDOG_EN
    localparam logic [7:0] C_TIMEOUT = 8'(TIMEOUT_CYC);

    logic [7:0] cnt_q, cnt_d;

    assign w_wdog_fire   = w_in_wait && (cnt_q == C_TIMEOUT);
    // Gated by rst so no stray pulse appears while reset is being applied.
    assign stall_timeout = rst && w_wdog_fire;

    // Counts cycles spent in a wait state; any exit (to RUN or REPLAY)
    // restarts it from zero for the next stall.
    always_comb begin
        cnt_d = 8'd0;
        if (w_in_wait && ((state_d == ST_WAIT_MEM) || (state_d == ST_WAIT_DIV))) begin
            cnt_d = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q <= 8'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    assign w_wdog_fire   = 1'b0;
    assign stall_timeout = 1'b0;
`endif

    // A branch resolved in the very cycle a stall ends still needs its replay.
    assign w_pend_any = flush_q || branch_taken;

    assign w_stall_done = ((state_q == ST_WAIT_MEM) && mem_ack) ||
                          ((state_q == ST_WAIT_DIV) && div_done);

    always_comb begin
        w_hold  = C_HF_RUN;
        state_d = state_q;
        flush_d = flush_q;
        if (!rst) begin
            w_hold = C_HF_FLUSH_ALL;
        end else if (trap_req || w_wdog_fire) begin
            w_hold  = C_HF_FLUSH_ALL;
            state_d = ST_RUN;
            flush_d = 1'b0;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (mem_req && !mem_ack) begin
                        w_hold  = C_HF_HOLD_ALL;
                        state_d = ST_WAIT_MEM;
                    end else if (div_start) begin
                        w_hold  = C_HF_HOLD_ALL;
                        state_d = ST_WAIT_DIV;
                    end else if (ld_use_hazard) begin
                        w_hold = C_HF_HOLD_FRONT;
                    end else if (branch_taken) begin
                        w_hold = C_HF_FLUSH_FRT;
                    end
                end
                ST_WAIT_MEM, ST_WAIT_DIV: begin
                    if (w_stall_done) begin
                        w_hold  = C_HF_RUN;
                        state_d = w_pend_any ? ST_REPLAY : ST_RUN;
                        flush_d = w_pend_any;
                    end else begin
                        w_hold  = C_HF_HOLD_ALL;
                        flush_d = w_pend_any;
                    end
                end
                default: begin
                    // ST_REPLAY: flush the wrong-path front end once.
                    w_hold  = C_HF_FLUSH_FRT;
                    state_d = ST_RUN;
                    flush_d = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_RUN;
            flush_q <= 1'b0;
        end else begin
            state_q <= state_d;
            flush_q <= flush_d;
        end
    end

    assign hold_flag  = w_hold;
    assign flush_pend = flush_q;

endmodule
`default_nettype wire
